// File: rtl/ihp13_sram_bist_pkg.sv
// Shared types and the March C- element table for the IHP13 SRAM BIST controller.
package ihp13_sram_bist_pkg;

  typedef enum logic [1:0] {OP_R0, OP_R1, OP_W0, OP_W1} march_op_e;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} march_state_e;

  localparam int NumElems = 6;

  typedef struct packed {
    logic      down;
    logic [1:0] n_ops;
    march_op_e op0;
    march_op_e op1;
  } march_elem_t;

  // Index 0 is E0; op1 is only meaningful when n_ops is 2.
  localparam march_elem_t [NumElems-1:0] MarchTable = '{
    '{1'b0, 2'd1, OP_R0, OP_R0},
    '{1'b1, 2'd2, OP_R1, OP_W0},
    '{1'b1, 2'd2, OP_R0, OP_W1},
    '{1'b0, 2'd2, OP_R1, OP_W0},
    '{1'b0, 2'd2, OP_R0, OP_W1},
    '{1'b0, 2'd1, OP_W0, OP_W0}
  };

  function automatic logic op_is_write(input march_op_e op);
    return (op == OP_W0) || (op == OP_W1);
  endfunction

endpackage

// File: rtl/ihp13_sram_bist_ctrl_if.sv
// BIST port of one IHP13 1P SRAM macro; master is the BIST controller, slave the macro.
interface ihp13_sram_bist_ctrl_if #(
  parameter int AddrWidth = 6,
  parameter int DataWidth = 64
);
  logic                 bist_en_o;
  logic                 bist_men_o;
  logic                 bist_wen_o;
  logic                 bist_ren_o;
  logic [AddrWidth-1:0] bist_addr_o;
  logic [DataWidth-1:0] bist_din_o;
  logic [DataWidth-1:0] bist_bm_o;
  logic [DataWidth-1:0] bist_dout_i;

  modport master (
    output bist_en_o, bist_men_o, bist_wen_o, bist_ren_o,
    output bist_addr_o, bist_din_o, bist_bm_o,
    input  bist_dout_i
  );

  modport slave (
    input  bist_en_o, bist_men_o, bist_wen_o, bist_ren_o,
    input  bist_addr_o, bist_din_o, bist_bm_o,
    output bist_dout_i
  );
endinterface

// File: rtl/ihp13_sram_bist_agen.sv
// Up/down March address counter; loads the start address for the element direction
// and stops on an explicit end-address compare so it never reaches unimplemented words.
module ihp13_sram_bist_agen #(
  parameter  int NumWords  = 64,
  localparam int AddrWidth = $clog2(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 i_clear,
  input  logic                 i_load,
  input  logic                 i_down,
  input  logic                 i_step,
  output logic [AddrWidth-1:0] o_addr,
  output logic                 o_first,
  output logic                 o_last
);
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

  logic [AddrWidth-1:0] r_addr;
  logic                 r_down;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr <= '0;
      r_down <= 1'b0;
    end else if (i_clear) begin
      r_addr <= '0;
      r_down <= 1'b0;
    end else if (i_load) begin
      r_addr <= i_down ? LastAddr : '0;
      r_down <= i_down;
    end else if (i_step && !o_last) begin
      r_addr <= r_down ? r_addr - AddrWidth'(1) : r_addr + AddrWidth'(1);
    end
  end

  assign o_addr  = r_addr;
  assign o_last  = r_down ? (r_addr == '0) : (r_addr == LastAddr);
  assign o_first = r_down ? (r_addr == LastAddr) : (r_addr == '0);
endmodule

// File: rtl/ihp13_sram_bist_ctrl.sv
// March C- BIST controller for one IHP13 1P SRAM macro: issues one operation per cycle,
// compares read data one cycle later and keeps pass/fail, first failure and error count.
module ihp13_sram_bist_ctrl
  import ihp13_sram_bist_pkg::*;
#(
  parameter  int NumWords  = 64,
  parameter  int DataWidth = 64,
  localparam int AddrWidth = $clog2(NumWords)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   fail_o,
  output logic [AddrWidth-1:0]   fail_addr_o,
  output logic [2:0]             fail_elem_o,
  output logic [15:0]            err_cnt_o,
  ihp13_sram_bist_ctrl_if.master bist
);
  march_state_e         r_state;
  logic [2:0]           r_elem, r_cmp_elem, r_fail_elem;
  logic                 r_opi, r_busy, r_done, r_wen, r_ren, r_men, r_din;
  logic                 r_cmp_vld, r_cmp_exp, r_fail;
  logic [AddrWidth-1:0] r_cmp_addr, r_fail_addr;
  logic [15:0]          r_err_cnt;

  logic [AddrWidth-1:0] w_addr;
  logic                 w_first, w_last, w_last_op, w_adv_elem, w_end, w_nxt_opi;
  logic                 w_start, w_run, w_load, w_load_down, w_step, w_clear, w_mismatch;
  logic [2:0]           w_nxt_elem;
  march_op_e            w_cur_op, w_nxt_op;

  // Next operation: advance op slot, then address, then element.
  always_comb begin
    w_cur_op    = r_opi ? MarchTable[r_elem].op1 : MarchTable[r_elem].op0;
    w_last_op   = ({1'b0, r_opi} == MarchTable[r_elem].n_ops - 2'd1);
    w_adv_elem  = w_last_op && w_last;
    w_end       = w_adv_elem && (r_elem == 3'(NumElems - 1));
    w_nxt_elem  = (w_adv_elem && !w_end) ? r_elem + 3'd1 : r_elem;
    w_nxt_opi   = !w_last_op;
    w_nxt_op    = w_nxt_opi ? MarchTable[w_nxt_elem].op1 : MarchTable[w_nxt_elem].op0;
    w_start     = (r_state == IDLE) && start_i && !abort_i;
    w_run       = (r_state == RUN) && !abort_i;
    w_clear     = (abort_i && (r_state != IDLE)) || (w_run && w_end);
    w_load      = w_start || (w_run && w_adv_elem && !w_end);
    w_load_down = w_start ? 1'b0 : MarchTable[w_nxt_elem].down;
    w_step      = w_run && w_last_op && !w_last;
    w_mismatch  = r_cmp_vld && (bist.bist_dout_i != {DataWidth{r_cmp_exp}});
  end

  ihp13_sram_bist_agen #(.NumWords(NumWords)) u_agen (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_clear (w_clear),
    .i_load  (w_load),
    .i_down  (w_load_down),
    .i_step  (w_step),
    .o_addr  (w_addr),
    .o_first (w_first),
    .o_last  (w_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_elem      <= '0;
      r_opi       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wen       <= 1'b0;
      r_ren       <= 1'b0;
      r_men       <= 1'b0;
      r_din       <= 1'b0;
      r_cmp_vld   <= 1'b0;
      r_cmp_exp   <= 1'b0;
      r_cmp_addr  <= '0;
      r_cmp_elem  <= '0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_done    <= 1'b0;
      r_cmp_vld <= 1'b0;
      // An abort in the compare cycle drops that compare.
      if (w_mismatch && !abort_i) begin
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        if (!r_fail) begin
          r_fail      <= 1'b1;
          r_fail_addr <= r_cmp_addr;
          r_fail_elem <= r_cmp_elem;
        end
      end
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state     <= RUN;
            r_busy      <= 1'b1;
            r_elem      <= '0;
            r_opi       <= 1'b0;
            r_wen       <= 1'b1;
            r_ren       <= 1'b0;
            r_men       <= 1'b1;
            r_din       <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
            r_err_cnt   <= '0;
          end
        end
        RUN: begin
          if (abort_i) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_wen   <= 1'b0;
            r_ren   <= 1'b0;
            r_men   <= 1'b0;
            r_din   <= 1'b0;
          end else begin
            r_cmp_vld  <= r_ren;
            r_cmp_exp  <= (w_cur_op == OP_R1);
            r_cmp_addr <= w_addr;
            r_cmp_elem <= r_elem;
            if (w_end) begin
              r_state <= DRAIN;
              r_wen   <= 1'b0;
              r_ren   <= 1'b0;
              r_men   <= 1'b0;
              r_din   <= 1'b0;
            end else begin
              r_elem <= w_nxt_elem;
              r_opi  <= w_nxt_opi;
              r_wen  <= op_is_write(w_nxt_op);
              r_ren  <= !op_is_write(w_nxt_op);
              r_men  <= 1'b1;
              r_din  <= (w_nxt_op == OP_W1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= !abort_i;
        end
      endcase
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) !(w_first && w_last));

  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign fail_o           = r_fail;
  assign fail_addr_o      = r_fail_addr;
  assign fail_elem_o      = r_fail_elem;
  assign err_cnt_o        = r_err_cnt;
  assign bist.bist_en_o   = r_busy;
  assign bist.bist_men_o  = r_men;
  assign bist.bist_wen_o  = r_wen;
  assign bist.bist_ren_o  = r_ren;
  assign bist.bist_addr_o = w_addr;
  assign bist.bist_din_o  = {DataWidth{r_din}};
  assign bist.bist_bm_o   = {DataWidth{r_wen}};
endmodule

// File: tb/tb_ihp13_sram_bist_ctrl.sv
// Bench for ihp13_sram_bist_ctrl: 64x64 macro model with stuck-at fault injection and
// an element-table March C- reference that predicts the bus sequence and results.
module tb_ihp13_sram_bist_ctrl;
  localparam int N  = 64;
  localparam int DW = 64;
  localparam int AW = 6;
  localparam int OPS = 10 * N;

  typedef struct packed { logic w; logic v; logic [AW-1:0] a; } op_t;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0;
  logic busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0] fail_elem;
  logic [15:0] err_cnt;
  int total = 0, bad = 0;

  bit f_en = 1'b0;
  int f_addr = 0, f_bit = 0;
  logic f_val = 1'b0;

  string march [6] = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};
  bit    desc  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  op_t   exp_q [$];

  ihp13_sram_bist_ctrl_if #(.AddrWidth(AW), .DataWidth(DW)) bif ();

  ihp13_sram_bist_ctrl #(.NumWords(N), .DataWidth(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .busy_o(busy), .done_o(done), .fail_o(fail), .fail_addr_o(fail_addr),
    .fail_elem_o(fail_elem), .err_cnt_o(err_cnt), .bist(bif)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] faulty(input logic [DW-1:0] d, input int a);
    logic [DW-1:0] r;
    r = d;
    if (f_en && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  // Macro model: one-cycle read latency, bit-masked write.
  logic [DW-1:0] mem [N];
  initial bif.bist_dout_i = '0;
  always @(posedge clk) begin
    if (bif.bist_men_o && bif.bist_wen_o)
      mem[bif.bist_addr_o] <= (mem[bif.bist_addr_o] & ~bif.bist_bm_o) | (bif.bist_din_o & bif.bist_bm_o);
    if (bif.bist_men_o && bif.bist_ren_o)
      bif.bist_dout_i <= faulty(mem[bif.bist_addr_o], int'(bif.bist_addr_o));
  end

  // Walks the element table; op c (1-based) occupies run cycle c and is compared at the
  // edge ending cycle c+1, which is lost if abort is sampled at or before that edge.
  task automatic build_model(input int abort_at, output int ecnt, output int faddr, output int felem);
    logic [DW-1:0] m [N];
    logic [DW-1:0] d, want;
    int c, a;
    bit seen;
    byte k, b;
    ecnt = 0; faddr = 0; felem = 0; seen = 1'b0; c = 0;
    exp_q.delete();
    for (int e = 0; e < 6; e++) begin
      for (int s = 0; s < N; s++) begin
        a = desc[e] ? N - 1 - s : s;
        for (int i = 0; i < march[e].len(); i += 2) begin
          k = march[e][i];
          b = march[e][i+1];
          want = (b == "1") ? '1 : '0;
          c++;
          exp_q.push_back(op_t'{w: (k == "w"), v: (b == "1"), a: AW'(a)});
          if (k == "w") m[a] = want;
          else begin
            d = faulty(m[a], a);
            if (d !== want && (abort_at == 0 || c + 1 < abort_at)) begin
              ecnt++;
              if (!seen) begin seen = 1'b1; faddr = a; felem = e; end
            end
          end
        end
      end
    end
  endtask

  task automatic run_march(input string name, input int abort_at, input bit hold);
    int ecnt, faddr, felem, dones;
    op_t eo;
    logic [DW-1:0] wdat;
    build_model(abort_at, ecnt, faddr, felem);
    @(posedge clk); #1 start = 1'b1;
    for (int j = 1; j <= OPS + 2; j++) begin
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      if (j == 1) begin
        total++;
        if (fail !== 1'b0 || err_cnt !== 16'd0) begin
          bad++;
          $display("FAIL %s start_clear: fail=%b err_cnt=%0d, required 0/0", name, fail, err_cnt);
        end
      end
      if (abort_at != 0 && j == abort_at + 1) begin
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || bif.bist_en_o !== 1'b0 || bif.bist_men_o !== 1'b0 || done !== 1'b0) begin
          bad++;
          $display("FAIL %s abort_idle: busy=%b en=%b men=%b done=%b, required all 0", name, busy, bif.bist_en_o, bif.bist_men_o, done);
        end
        total++;
        if (fail !== (ecnt != 0) || err_cnt !== 16'(ecnt) || fail_addr !== AW'(faddr) || fail_elem !== 3'(felem)) begin
          bad++;
          $display("FAIL %s abort_results: fail=%b err=%0d addr=%0d elem=%0d, required %b/%0d/%0d/%0d", name, fail, err_cnt, fail_addr, fail_elem, ecnt != 0, ecnt, faddr, felem);
        end
        break;
      end
      if (j <= OPS) begin
        eo = exp_q[j-1];
        wdat = eo.v ? '1 : '0;
        total++;
        if (bif.bist_wen_o !== eo.w || bif.bist_ren_o !== !eo.w || bif.bist_men_o !== 1'b1 || bif.bist_addr_o !== eo.a
            || bif.bist_bm_o !== (eo.w ? {DW{1'b1}} : {DW{1'b0}}) || (eo.w && bif.bist_din_o !== wdat)
            || busy !== 1'b1 || bif.bist_en_o !== 1'b1 || done !== 1'b0) begin
          bad++;
          $display("FAIL %s op cycle %0d: wen=%b ren=%b men=%b addr=%0d din=%h busy=%b done=%b, required wen=%b ren=%b addr=%0d din=%h busy=1 done=0",
                   name, j, bif.bist_wen_o, bif.bist_ren_o, bif.bist_men_o, bif.bist_addr_o, bif.bist_din_o, busy, done, eo.w, !eo.w, eo.a, wdat);
        end
      end else if (j == OPS + 1) begin
        total++;
        if (busy !== 1'b1 || bif.bist_en_o !== 1'b1 || bif.bist_men_o !== 1'b0 || bif.bist_wen_o !== 1'b0 || bif.bist_ren_o !== 1'b0 || done !== 1'b0) begin
          bad++;
          $display("FAIL %s drain: busy=%b en=%b men=%b wen=%b ren=%b done=%b, required 1/1/0/0/0/0", name, busy, bif.bist_en_o, bif.bist_men_o, bif.bist_wen_o, bif.bist_ren_o, done);
        end
      end else begin
        start = 1'b0;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || bif.bist_en_o !== 1'b0 || bif.bist_men_o !== 1'b0 || bif.bist_addr_o !== '0 || bif.bist_din_o !== '0 || bif.bist_bm_o !== '0) begin
          bad++;
          $display("FAIL %s done_cycle %0d: done=%b busy=%b en=%b men=%b addr=%0d, required done=1 rest 0", name, j, done, busy, bif.bist_en_o, bif.bist_men_o, bif.bist_addr_o);
        end
        total++;
        if (fail !== (ecnt != 0) || err_cnt !== 16'(ecnt) || fail_addr !== AW'(faddr) || fail_elem !== 3'(felem)) begin
          bad++;
          $display("FAIL %s results: fail=%b err=%0d addr=%0d elem=%0d, required %b/%0d/%0d/%0d", name, fail, err_cnt, fail_addr, fail_elem, ecnt != 0, ecnt, faddr, felem);
        end
      end
      if (abort_at != 0 && j == abort_at) abort = 1'b1;
    end
    if (abort_at != 0) begin
      dones = 0;
      repeat (OPS + 10) begin
        @(posedge clk); #1;
        if (done !== 1'b0 || busy !== 1'b0) dones++;
      end
      total++;
      if (dones != 0 || err_cnt !== 16'(ecnt) || fail !== (ecnt != 0)) begin
        bad++;
        $display("FAIL %s after_abort: done/busy cycles=%0d err=%0d fail=%b, required 0/%0d/%b", name, dones, err_cnt, fail, ecnt, ecnt != 0);
      end
    end
  endtask

  task automatic set_fault(input bit en, input int a, input int b, input logic v);
    f_en = en; f_addr = a; f_bit = b; f_val = v;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0 || err_cnt !== 16'd0 || fail_addr !== '0 || fail_elem !== 3'd0
        || bif.bist_en_o !== 1'b0 || bif.bist_men_o !== 1'b0 || bif.bist_addr_o !== '0 || bif.bist_bm_o !== '0) begin
      bad++;
      $display("FAIL reset_values: busy=%b done=%b fail=%b err=%0d en=%b men=%b addr=%0d, required all 0", busy, done, fail, err_cnt, bif.bist_en_o, bif.bist_men_o, bif.bist_addr_o);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || bif.bist_en_o !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b en=%b, required 0/0", busy, bif.bist_en_o);
    end
  endtask

  task automatic test_fault_free;
    set_fault(1'b0, 0, 0, 1'b0);
    run_march("fault_free", 0, 1'b0);
  endtask

  task automatic test_stuck_at;
    set_fault(1'b1, 17, 5, 1'b1);
    run_march("sa1_a17_b5", 0, 1'b0);
    set_fault(1'b1, 0, 63, 1'b0);
    run_march("sa0_a0_b63", 0, 1'b0);
  endtask

  task automatic test_random_faults;
    for (int n = 0; n < 3; n++) begin
      set_fault(1'b1, $urandom_range(N - 1, 0), $urandom_range(DW - 1, 0), 1'($urandom_range(1, 0)));
      run_march("rand_fault", 0, 1'b0);
    end
  endtask

  task automatic test_abort;
    set_fault(1'b1, 17, 5, 1'b1);
    run_march("abort100", 100, 1'b0);
    set_fault(1'b1, $urandom_range(N - 1, 0), $urandom_range(DW - 1, 0), 1'($urandom_range(1, 0)));
    run_march("abort_rand", $urandom_range(OPS + 1, 2), 1'b0);
    set_fault(1'b0, 0, 0, 1'b0);
    run_march("after_abort", 0, 1'b0);
  endtask

  task automatic test_reset_mid;
    int busy_cycles;
    set_fault(1'b1, 3, 1, 1'b1);
    @(posedge clk); #1 start = 1'b1;
    for (int j = 1; j <= 300; j++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0 || err_cnt !== 16'd0 || fail_addr !== '0 || fail_elem !== 3'd0
        || bif.bist_en_o !== 1'b0 || bif.bist_men_o !== 1'b0 || bif.bist_wen_o !== 1'b0 || bif.bist_ren_o !== 1'b0
        || bif.bist_addr_o !== '0 || bif.bist_din_o !== '0 || bif.bist_bm_o !== '0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b fail=%b err=%0d en=%b men=%b addr=%0d, required all 0", busy, fail, err_cnt, bif.bist_en_o, bif.bist_men_o, bif.bist_addr_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    busy_cycles = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || bif.bist_en_o !== 1'b0 || done !== 1'b0) busy_cycles++;
    end
    total++;
    if (busy_cycles != 0) begin
      bad++;
      $display("FAIL reset_release_idle: active cycles=%0d, required 0", busy_cycles);
    end
  endtask

  task automatic test_start_held;
    set_fault(1'b1, 17, 5, 1'b1);
    run_march("held_start", 0, 1'b1);
    set_fault(1'b0, 0, 0, 1'b0);
    run_march("after_held", 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_stuck_at();
    test_random_faults();
    test_abort();
    test_reset_mid();
    test_start_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
